// File: rtl/airi5c_fpu_issue_queue.sv
// airi5c_fpu_issue_queue
// Buffered issue front-end for the FP execution unit. Requests are queued in a
// small circular FIFO and issued one at a time with a one-cycle load strobe.
// Each result is held on a valid/ready response port together with its tag.
// Optional feature: define FPU_FLAG_ACCUM_EN to add a sticky accumulator of
// response flags (fflags_clr / fflags_acc ports).
module airi5c_fpu_issue_queue #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter int OP_W   = 22,
  parameter int TAG_W  = 5
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       kill,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [OP_W-1:0]            req_op,
  input  logic [2:0]                 req_rm,
  input  logic [DATA_W-1:0]          req_a,
  input  logic [DATA_W-1:0]          req_b,
  input  logic [TAG_W-1:0]           req_tag,
  output logic                       exu_load,
  output logic                       exu_kill,
  output logic [OP_W-1:0]            exu_op,
  output logic [2:0]                 exu_rm,
  output logic [DATA_W-1:0]          exu_a,
  output logic [DATA_W-1:0]          exu_b,
  input  logic [DATA_W-1:0]          exu_result,
  input  logic [4:0]                 exu_flags,
  input  logic                       exu_ready,
  output logic                       resp_valid,
  input  logic                       resp_ready,
  output logic [DATA_W-1:0]          resp_result,
  output logic [4:0]                 resp_flags,
  output logic [TAG_W-1:0]           resp_tag,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       busy
`ifdef FPU_FLAG_ACCUM_EN
  ,
  input  logic                       fflags_clr,
  output logic [4:0]                 fflags_acc
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  // Request storage, one slot per queued operation
  logic [OP_W-1:0]   r_memOp  [DEPTH];
  logic [2:0]        r_memRm  [DEPTH];
  logic [DATA_W-1:0] r_memA   [DEPTH];
  logic [DATA_W-1:0] r_memB   [DEPTH];
  logic [TAG_W-1:0]  r_memTag [DEPTH];

  logic [PTR_W-1:0]  r_wrPtr;
  logic [PTR_W-1:0]  r_rdPtr;
  logic [CNT_W-1:0]  r_count;

  state_t            r_state;
  logic [TAG_W-1:0]  r_issueTag;
  logic              r_respValid;
  logic [DATA_W-1:0] r_respResult;
  logic [4:0]        r_respFlags;
  logic [TAG_W-1:0]  r_respTag;

  logic w_empty;
  logic w_full;
  logic w_push;
  logic w_pop;
  logic w_respHs;

  assign w_empty  = (r_count == '0);
  assign w_full   = (r_count == FULL_CNT);
  assign w_respHs = r_respValid & resp_ready;

  // Issue happens from IDLE, or from RESP in the same cycle the response is taken
  assign w_pop = !reset && !kill && !w_empty &&
                 ((r_state == S_IDLE) || ((r_state == S_RESP) && resp_ready));
  assign w_push = req_valid && req_ready && !reset;

  assign req_ready = !w_full && !kill;
  assign exu_load  = w_pop;
  assign exu_kill  = kill | reset;
  assign exu_op    = r_memOp[r_rdPtr];
  assign exu_rm    = r_memRm[r_rdPtr];
  assign exu_a     = r_memA[r_rdPtr];
  assign exu_b     = r_memB[r_rdPtr];

  assign resp_valid  = r_respValid;
  assign resp_result = r_respResult;
  assign resp_flags  = r_respFlags;
  assign resp_tag    = r_respTag;
  assign count       = r_count;
  assign busy        = (r_count != '0) || (r_state != S_IDLE);

  // Write an accepted request into the tail slot; storage needs no reset
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_memOp[r_wrPtr]  <= req_op;
      r_memRm[r_wrPtr]  <= req_rm;
      r_memA[r_wrPtr]   <= req_a;
      r_memB[r_wrPtr]   <= req_b;
      r_memTag[r_wrPtr] <= req_tag;
    end
  end

  // Pointer and occupancy bookkeeping; kill or reset empties the queue
  always_ff @(posedge clk) begin
    if (reset || kill) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_pop)  r_rdPtr <= r_rdPtr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_push && w_pop) r_count <= r_count - 1'b1;
    end
  end

  // Issue/complete sequencer with registered response outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_issueTag   <= '0;
      r_respValid  <= 1'b0;
      r_respResult <= '0;
      r_respFlags  <= '0;
      r_respTag    <= '0;
    end else if (kill) begin
      r_state     <= S_IDLE;
      r_respValid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_issueTag <= r_memTag[r_rdPtr];
            r_state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (exu_ready) begin
            r_respResult <= exu_result;
            r_respFlags  <= exu_flags;
            r_respTag    <= r_issueTag;
            r_respValid  <= 1'b1;
            r_state      <= S_RESP;
          end
        end
        S_RESP: begin
          if (resp_ready) begin
            r_respValid <= 1'b0;
            if (w_pop) begin
              r_issueTag <= r_memTag[r_rdPtr];
              r_state    <= S_WAIT;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef FPU_FLAG_ACCUM_EN
  logic [4:0] r_flagAcc;

  assign fflags_acc = r_flagAcc;

  // Sticky OR of every consumed response's flags; a clear still keeps a coincident response
  always_ff @(posedge clk) begin
    if (reset) begin
      r_flagAcc <= '0;
    end else if (fflags_clr) begin
      r_flagAcc <= w_respHs ? r_respFlags : 5'b0;
    end else if (w_respHs) begin
      r_flagAcc <= r_flagAcc | r_respFlags;
    end
  end
`endif

endmodule

// File: tb/tb_airi5c_fpu_issue_queue.sv
// Self-checking bench for airi5c_fpu_issue_queue: a table of single-cycle
// vectors for two isolated operations, then hand-written sequences for fill,
// backpressure, simultaneous push/pop with pointer wrap, kill, and mid-op reset.
module tb_airi5c_fpu_issue_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        kill;
  logic        req_valid;
  logic        req_ready;
  logic [21:0] req_op;
  logic [2:0]  req_rm;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [4:0]  req_tag;
  logic        exu_load;
  logic        exu_kill;
  logic [21:0] exu_op;
  logic [2:0]  exu_rm;
  logic [31:0] exu_a;
  logic [31:0] exu_b;
  logic [31:0] exu_result;
  logic [4:0]  exu_flags;
  logic        exu_ready;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_result;
  logic [4:0]  resp_flags;
  logic [4:0]  resp_tag;
  logic [2:0]  count;
  logic        busy;
`ifdef FPU_FLAG_ACCUM_EN
  logic        fflags_clr;
  logic [4:0]  fflags_acc;
`endif

  int errors = 0;
  int checks = 0;

  // EU stand-in: either hand-driven, or a fixed two-cycle unit returning a+1 with flags=a[4:0]
  bit          euManual = 1'b1;
  logic        manReady = 1'b0;
  logic [31:0] manResult = '0;
  logic [4:0]  manFlags = '0;
  int          euCnt = 0;
  logic [31:0] euRes = '0;
  logic [4:0]  euFl = '0;

  assign exu_ready  = euManual ? manReady  : (euCnt == 1);
  assign exu_result = euManual ? manResult : euRes;
  assign exu_flags  = euManual ? manFlags  : euFl;

  typedef struct {
    logic        reqValid;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  tag;
    logic [2:0]  rm;
    logic [21:0] op;
    logic        exuReady;
    logic [31:0] exuResult;
    logic [4:0]  exuFlags;
    logic        respReady;
    logic        expReqReady;
    logic        expLoad;
    logic        expRespValid;
    logic [2:0]  expCount;
    logic        expBusy;
    logic [31:0] expA;
    logic [31:0] expB;
    logic [21:0] expOp;
    logic [2:0]  expRm;
    logic [31:0] expResult;
    logic [4:0]  expFlags;
    logic [4:0]  expTag;
  } vec_t;

  vec_t vecs[$];

  logic [4:0]  drainTag [5] = '{5'd9, 5'd0, 5'd1, 5'd2, 5'd3};
  logic [31:0] drainRes [5] = '{32'h20A, 32'h101, 32'h102, 32'h103, 32'h104};
  logic [4:0]  drainFl  [5] = '{5'h09, 5'h00, 5'h01, 5'h02, 5'h03};
  logic [4:0]  wrapTag  [3] = '{5'd11, 5'd12, 5'd13};
  logic [31:0] wrapRes  [3] = '{32'h30C, 32'h30D, 32'h30E};

  airi5c_fpu_issue_queue dut (
    .clk         (clk),
    .reset       (reset),
    .kill        (kill),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_rm      (req_rm),
    .req_a       (req_a),
    .req_b       (req_b),
    .req_tag     (req_tag),
    .exu_load    (exu_load),
    .exu_kill    (exu_kill),
    .exu_op      (exu_op),
    .exu_rm      (exu_rm),
    .exu_a       (exu_a),
    .exu_b       (exu_b),
    .exu_result  (exu_result),
    .exu_flags   (exu_flags),
    .exu_ready   (exu_ready),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_result (resp_result),
    .resp_flags  (resp_flags),
    .resp_tag    (resp_tag),
    .count       (count),
    .busy        (busy)
`ifdef FPU_FLAG_ACCUM_EN
    ,
    .fflags_clr  (fflags_clr),
    .fflags_acc  (fflags_acc)
`endif
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  // Automatic EU: a load restarts a two-cycle countdown, ready when it reaches one
  always @(posedge clk) begin
    if (exu_kill) begin
      euCnt <= 0;
    end else if (exu_load) begin
      euCnt <= 2;
      euRes <= exu_a + 32'd1;
      euFl  <= exu_a[4:0];
    end else if (euCnt != 0) begin
      euCnt <= euCnt - 1;
    end
  end

  // Hard stop in case a sequence never returns
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time got 500000 expected completion earlier");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Move to one time unit after the next falling edge, where inputs are changed
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic waitResp(input string name);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 20; n++) begin
      #1;
      if (resp_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    checkOutput({name, "_arrive"}, 64'(ok), 64'(1));
  endtask

  task automatic pushOne(input string name, input logic [4:0] tag, input logic [31:0] a);
    req_valid = 1'b1;
    req_tag   = tag;
    req_a     = a;
    req_b     = 32'h0;
    req_op    = 22'h1;
    req_rm    = 3'd0;
    #1;
    checkOutput({name, "_req_ready"}, 64'(req_ready), 64'(1));
    tick();
    req_valid = 1'b0;
  endtask

  task automatic applyStimulus(input int idx, input vec_t v);
    string p;
    p = $sformatf("row%0d", idx);
    req_valid  = v.reqValid;
    req_a      = v.a;
    req_b      = v.b;
    req_tag    = v.tag;
    req_rm     = v.rm;
    req_op     = v.op;
    manReady   = v.exuReady;
    manResult  = v.exuResult;
    manFlags   = v.exuFlags;
    resp_ready = v.respReady;
    #1;
    checkOutput({p, "_req_ready"}, 64'(req_ready), 64'(v.expReqReady));
    checkOutput({p, "_exu_load"}, 64'(exu_load), 64'(v.expLoad));
    checkOutput({p, "_exu_kill"}, 64'(exu_kill), 64'(0));
    checkOutput({p, "_resp_valid"}, 64'(resp_valid), 64'(v.expRespValid));
    checkOutput({p, "_count"}, 64'(count), 64'(v.expCount));
    checkOutput({p, "_busy"}, 64'(busy), 64'(v.expBusy));
    if (v.expLoad) begin
      checkOutput({p, "_exu_a"}, 64'(exu_a), 64'(v.expA));
      checkOutput({p, "_exu_b"}, 64'(exu_b), 64'(v.expB));
      checkOutput({p, "_exu_op"}, 64'(exu_op), 64'(v.expOp));
      checkOutput({p, "_exu_rm"}, 64'(exu_rm), 64'(v.expRm));
    end
    if (v.expRespValid) begin
      checkOutput({p, "_resp_result"}, 64'(resp_result), 64'(v.expResult));
      checkOutput({p, "_resp_flags"}, 64'(resp_flags), 64'(v.expFlags));
      checkOutput({p, "_resp_tag"}, 64'(resp_tag), 64'(v.expTag));
    end
    tick();
  endtask

  task automatic addVec(
    input logic rv, input logic [31:0] a, input logic [31:0] b, input logic [4:0] tag,
    input logic [2:0] rm, input logic [21:0] op,
    input logic er, input logic [31:0] res, input logic [4:0] fl, input logic rr,
    input logic eRr, input logic eLoad, input logic eRv, input logic [2:0] eCnt, input logic eBusy,
    input logic [31:0] eA, input logic [31:0] eB, input logic [21:0] eOp, input logic [2:0] eRm,
    input logic [31:0] eRes, input logic [4:0] eFl, input logic [4:0] eTag);
    vec_t v;
    v.reqValid = rv;  v.a = a;  v.b = b;  v.tag = tag;  v.rm = rm;  v.op = op;
    v.exuReady = er;  v.exuResult = res;  v.exuFlags = fl;  v.respReady = rr;
    v.expReqReady = eRr;  v.expLoad = eLoad;  v.expRespValid = eRv;
    v.expCount = eCnt;  v.expBusy = eBusy;
    v.expA = eA;  v.expB = eB;  v.expOp = eOp;  v.expRm = eRm;
    v.expResult = eRes;  v.expFlags = eFl;  v.expTag = eTag;
    vecs.push_back(v);
  endtask

  initial begin
    reset = 1'b1;  kill = 1'b0;  req_valid = 1'b0;  req_op = '0;  req_rm = '0;
    req_a = '0;  req_b = '0;  req_tag = '0;  resp_ready = 1'b0;
`ifdef FPU_FLAG_ACCUM_EN
    fflags_clr = 1'b0;
`endif

    // Op 1: 1.0 + 2.0 tag 3, EU answers in its second WAIT cycle.
    // Op 2: -2.0 op 1.0 tag 17, EU answers in its first WAIT cycle with IE flag.
    //     rv a             b             tag rm op          er res           fl rr   rr ld rv cnt bsy eA            eB            eOp          eRm eRes          eFl eTag
    addVec(0, 32'h0,        32'h0,        0,  0, 22'h0,      0, 32'h0,        0, 0,   1, 0, 0, 0, 0, 32'h0,        32'h0,        22'h0,       0,  32'h0,        0,  0);
    addVec(1, 32'h3F800000, 32'h40000000, 3,  2, 22'h4,      0, 32'h0,        0, 0,   1, 0, 0, 0, 0, 32'h0,        32'h0,        22'h0,       0,  32'h0,        0,  0);
    addVec(0, 32'h0,        32'h0,        0,  0, 22'h0,      0, 32'h0,        0, 0,   1, 1, 0, 1, 1, 32'h3F800000, 32'h40000000, 22'h4,       2,  32'h0,        0,  0);
    addVec(0, 32'h0,        32'h0,        0,  0, 22'h0,      0, 32'h0,        0, 0,   1, 0, 0, 0, 1, 32'h0,        32'h0,        22'h0,       0,  32'h0,        0,  0);
    addVec(0, 32'h0,        32'h0,        0,  0, 22'h0,      1, 32'h40400000, 0, 0,   1, 0, 0, 0, 1, 32'h0,        32'h0,        22'h0,       0,  32'h0,        0,  0);
    addVec(0, 32'h0,        32'h0,        0,  0, 22'h0,      0, 32'h0,        0, 0,   1, 0, 1, 0, 1, 32'h0,        32'h0,        22'h0,       0,  32'h40400000, 0,  3);
    addVec(0, 32'h0,        32'h0,        0,  0, 22'h0,      0, 32'h0,        0, 1,   1, 0, 1, 0, 1, 32'h0,        32'h0,        22'h0,       0,  32'h40400000, 0,  3);
    addVec(0, 32'h0,        32'h0,        0,  0, 22'h0,      0, 32'h0,        0, 0,   1, 0, 0, 0, 0, 32'h0,        32'h0,        22'h0,       0,  32'h0,        0,  0);
    addVec(1, 32'hC0000000, 32'h3F800000, 17, 1, 22'h200000, 0, 32'h0,        0, 0,   1, 0, 0, 0, 0, 32'h0,        32'h0,        22'h0,       0,  32'h0,        0,  0);
    addVec(0, 32'h0,        32'h0,        0,  0, 22'h0,      0, 32'h0,        0, 0,   1, 1, 0, 1, 1, 32'hC0000000, 32'h3F800000, 22'h200000,  1,  32'h0,        0,  0);
    addVec(0, 32'h0,        32'h0,        0,  0, 22'h0,      1, 32'hBF800000, 1, 0,   1, 0, 0, 0, 1, 32'h0,        32'h0,        22'h0,       0,  32'h0,        0,  0);
    addVec(0, 32'h0,        32'h0,        0,  0, 22'h0,      0, 32'h0,        0, 1,   1, 0, 1, 0, 1, 32'h0,        32'h0,        22'h0,       0,  32'hBF800000, 1,  17);
    addVec(0, 32'h0,        32'h0,        0,  0, 22'h0,      0, 32'h0,        0, 0,   1, 0, 0, 0, 0, 32'h0,        32'h0,        22'h0,       0,  32'h0,        0,  0);

    // Reset state
    tick();
    checkOutput("rst_exu_kill", 64'(exu_kill), 64'(1));
    checkOutput("rst_exu_load", 64'(exu_load), 64'(0));
    tick();
    reset = 1'b0;
    #1;
    checkOutput("rst_resp_valid", 64'(resp_valid), 64'(0));
    checkOutput("rst_resp_result", 64'(resp_result), 64'(0));
    checkOutput("rst_resp_flags", 64'(resp_flags), 64'(0));
    checkOutput("rst_resp_tag", 64'(resp_tag), 64'(0));
    checkOutput("rst_count", 64'(count), 64'(0));
    checkOutput("rst_busy", 64'(busy), 64'(0));
    checkOutput("rst_exu_kill_off", 64'(exu_kill), 64'(0));
`ifdef FPU_FLAG_ACCUM_EN
    checkOutput("rst_fflags_acc", 64'(fflags_acc), 64'(0));
`endif
    tick();

    // Table-driven single operations
    foreach (vecs[i]) applyStimulus(i, vecs[i]);

    // Fill behind a held response, backpressure, then in-order drain
    euManual   = 1'b0;
    resp_ready = 1'b0;
    pushOne("fill_t9", 5'd9, 32'h209);
    waitResp("fill_t9");
    tick();
    for (int i = 0; i < 4; i++) pushOne($sformatf("fill_t%0d", i), 5'(i), 32'h100 + 32'(i));
    req_valid = 1'b1;
    req_tag   = 5'd7;
    req_a     = 32'h777;
    #1;
    checkOutput("fill_full_req_ready", 64'(req_ready), 64'(0));
    checkOutput("fill_full_count", 64'(count), 64'(4));
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #1;
      checkOutput($sformatf("bp%0d_resp_valid", i), 64'(resp_valid), 64'(1));
      checkOutput($sformatf("bp%0d_resp_tag", i), 64'(resp_tag), 64'(9));
      checkOutput($sformatf("bp%0d_resp_result", i), 64'(resp_result), 64'(32'h20A));
      checkOutput($sformatf("bp%0d_exu_load", i), 64'(exu_load), 64'(0));
      checkOutput($sformatf("bp%0d_count", i), 64'(count), 64'(4));
      tick();
    end
    resp_ready = 1'b1;
    #1;
    checkOutput("release_exu_load", 64'(exu_load), 64'(1));
    checkOutput("release_exu_a", 64'(exu_a), 64'(32'h100));
    for (int k = 0; k < 5; k++) begin
      waitResp($sformatf("drain%0d", k));
      checkOutput($sformatf("drain%0d_tag", k), 64'(resp_tag), 64'(drainTag[k]));
      checkOutput($sformatf("drain%0d_result", k), 64'(resp_result), 64'(drainRes[k]));
      checkOutput($sformatf("drain%0d_flags", k), 64'(resp_flags), 64'(drainFl[k]));
      checkOutput($sformatf("drain%0d_exu_load", k), 64'(exu_load), 64'(k < 4));
      tick();
    end
    #1;
    checkOutput("drain_end_count", 64'(count), 64'(0));
    checkOutput("drain_end_busy", 64'(busy), 64'(0));
    tick();

    // Simultaneous push and pop at count=2; pointers have wrapped by now
    resp_ready = 1'b0;
    pushOne("wrap_t10", 5'd10, 32'h30A);
    waitResp("wrap_t10");
    tick();
    pushOne("wrap_t11", 5'd11, 32'h30B);
    pushOne("wrap_t12", 5'd12, 32'h30C);
    req_valid  = 1'b1;
    req_tag    = 5'd13;
    req_a      = 32'h30D;
    resp_ready = 1'b1;
    #1;
    checkOutput("pushpop_exu_load", 64'(exu_load), 64'(1));
    checkOutput("pushpop_req_ready", 64'(req_ready), 64'(1));
    checkOutput("pushpop_count_before", 64'(count), 64'(2));
    checkOutput("pushpop_exu_a", 64'(exu_a), 64'(32'h30B));
    tick();
    req_valid = 1'b0;
    #1;
    checkOutput("pushpop_count_after", 64'(count), 64'(2));
    for (int k = 0; k < 3; k++) begin
      waitResp($sformatf("wrap%0d", k));
      checkOutput($sformatf("wrap%0d_tag", k), 64'(resp_tag), 64'(wrapTag[k]));
      checkOutput($sformatf("wrap%0d_result", k), 64'(resp_result), 64'(wrapRes[k]));
      tick();
    end
    #1;
    checkOutput("wrap_end_busy", 64'(busy), 64'(0));
    tick();

    // Kill while waiting on the EU with three requests queued
    euManual   = 1'b1;
    manReady   = 1'b0;
    resp_ready = 1'b0;
    for (int i = 0; i < 4; i++) pushOne($sformatf("kill_t%0d", 20 + i), 5'(20 + i), 32'h400 + 32'(i));
    #1;
    checkOutput("prekill_count", 64'(count), 64'(3));
    checkOutput("prekill_busy", 64'(busy), 64'(1));
    checkOutput("prekill_resp_valid", 64'(resp_valid), 64'(0));
    tick();
    kill      = 1'b1;
    req_valid = 1'b1;
    req_tag   = 5'd24;
    #1;
    checkOutput("kill_exu_kill", 64'(exu_kill), 64'(1));
    checkOutput("kill_exu_load", 64'(exu_load), 64'(0));
    checkOutput("kill_req_ready", 64'(req_ready), 64'(0));
    tick();
    kill      = 1'b0;
    req_valid = 1'b0;
    manReady  = 1'b1;
    manResult = 32'hDEADBEEF;
    #1;
    checkOutput("postkill_count", 64'(count), 64'(0));
    checkOutput("postkill_resp_valid", 64'(resp_valid), 64'(0));
    checkOutput("postkill_exu_load", 64'(exu_load), 64'(0));
    tick();
    manReady = 1'b0;
    #1;
    checkOutput("late_ready_resp_valid", 64'(resp_valid), 64'(0));
    checkOutput("late_ready_busy", 64'(busy), 64'(0));
    tick();

    // Reset while a response is pending
    euManual = 1'b0;
    pushOne("midrst_t25", 5'd25, 32'h3FF);
    waitResp("midrst_t25");
    checkOutput("midrst_pre_tag", 64'(resp_tag), 64'(25));
    tick();
    reset = 1'b1;
    #1;
    checkOutput("midrst_exu_kill", 64'(exu_kill), 64'(1));
    checkOutput("midrst_exu_load", 64'(exu_load), 64'(0));
    tick();
    reset = 1'b0;
    #1;
    checkOutput("midrst_resp_valid", 64'(resp_valid), 64'(0));
    checkOutput("midrst_resp_tag", 64'(resp_tag), 64'(0));
    checkOutput("midrst_resp_result", 64'(resp_result), 64'(0));
    checkOutput("midrst_count", 64'(count), 64'(0));
    tick();

`ifdef FPU_FLAG_ACCUM_EN
    // Flag accumulation across two responses, then clear
    resp_ready = 1'b1;
    pushOne("acc_op1", 5'd1, 32'h01);
    waitResp("acc_op1");
    tick();
    pushOne("acc_op2", 5'd2, 32'h10);
    waitResp("acc_op2");
    tick();
    #1;
    checkOutput("acc_value", 64'(fflags_acc), 64'(5'h11));
    tick();
    fflags_clr = 1'b1;
    tick();
    fflags_clr = 1'b0;
    #1;
    checkOutput("acc_cleared", 64'(fflags_acc), 64'(0));
    tick();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
